// File: rtl/updown_cntr_sequencer.sv
// Control sequencer for the preset-able up/down counter: load, count up, pause,
// then count down until the counter expires or the down-phase watchdog fires.
module updown_cntr_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DUR_W = 8
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_preset_value,
  input  logic [DUR_W-1:0] cfg_up_cycles,
  input  logic [DUR_W-1:0] cfg_hold_cycles,
  input  logic [DUR_W-1:0] cfg_dn_timeout,
  input  logic             ctr_expired,
  output logic             new_cntr_preset,
  output logic [WIDTH-1:0] new_cntr_preset_value,
  output logic             enable_cnt_up,
  output logic             enable_cnt_dn,
  output logic             pause_counting,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_HOLD = 3'd3,
    S_DOWN = 3'd4,
    S_DONE = 3'd5
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] preset;
    logic [DUR_W-1:0] up;
    logic [DUR_W-1:0] hold;
    logic [DUR_W-1:0] tmo;
  } profile_t;

  state_t           state;
  state_t           next_state;
  profile_t         shd;
  logic [DUR_W-1:0] dur_cnt;

  logic             start_acc_c;
  logic             up_last_c;
  logic             hold_last_c;
  logic             tmo_hit_c;

  logic             preset_d_c;
  logic             up_d_c;
  logic             dn_d_c;
  logic             pause_d_c;
  logic             busy_d_c;
  logic             done_d_c;
  logic             terr_d_c;
  logic [WIDTH-1:0] value_d_c;

  // Phase-end decodes: the duration counter restarts at 0 on every state entry.
  assign up_last_c   = (dur_cnt == (shd.up - DUR_W'(1)));
  assign hold_last_c = (dur_cnt == (shd.hold - DUR_W'(1)));
  assign tmo_hit_c   = (shd.tmo != '0) && (dur_cnt == (shd.tmo - DUR_W'(1)));

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state plus next-cycle output values; outputs are registered below.
  always_comb begin
    next_state  = state;
    start_acc_c = 1'b0;
    terr_d_c    = timeout_err;
    value_d_c   = new_cntr_preset_value;

    case (state)
      S_IDLE: begin
        if (start) begin
          next_state  = S_LOAD;
          start_acc_c = 1'b1;
          terr_d_c    = 1'b0;
          value_d_c   = cfg_preset_value;
        end
      end
      S_LOAD: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (shd.up != '0) begin
          next_state = S_UP;
        end else if (shd.hold != '0) begin
          next_state = S_HOLD;
        end else begin
          next_state = S_DOWN;
        end
      end
      S_UP: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (up_last_c) begin
          next_state = (shd.hold != '0) ? S_HOLD : S_DOWN;
        end
      end
      S_HOLD: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (hold_last_c) begin
          next_state = S_DOWN;
        end
      end
      S_DOWN: begin
        // Expiry takes precedence over a coincident watchdog hit.
        if (abort) begin
          next_state = S_IDLE;
        end else if (ctr_expired) begin
          next_state = S_DONE;
        end else if (tmo_hit_c) begin
          next_state = S_DONE;
          terr_d_c   = 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase

    preset_d_c = (next_state == S_LOAD);
    up_d_c     = (next_state == S_UP);
    pause_d_c  = (next_state == S_HOLD);
    dn_d_c     = (next_state == S_DOWN);
    done_d_c   = (next_state == S_DONE);
    busy_d_c   = (next_state != S_IDLE);
  end

  // Shadow profile, captured only when a start is accepted.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      shd <= '0;
    end else if (start_acc_c) begin
      shd.preset <= cfg_preset_value;
      shd.up     <= cfg_up_cycles;
      shd.hold   <= cfg_hold_cycles;
      shd.tmo    <= cfg_dn_timeout;
    end
  end

  // Per-state duration counter; saturates instead of wrapping.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      dur_cnt <= '0;
    end else if (next_state != state) begin
      dur_cnt <= '0;
    end else if (dur_cnt != '1) begin
      dur_cnt <= dur_cnt + DUR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      new_cntr_preset       <= 1'b0;
      new_cntr_preset_value <= '0;
      enable_cnt_up         <= 1'b0;
      enable_cnt_dn         <= 1'b0;
      pause_counting        <= 1'b0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      timeout_err           <= 1'b0;
    end else begin
      new_cntr_preset       <= preset_d_c;
      new_cntr_preset_value <= value_d_c;
      enable_cnt_up         <= up_d_c;
      enable_cnt_dn         <= dn_d_c;
      pause_counting        <= pause_d_c;
      busy                  <= busy_d_c;
      done                  <= done_d_c;
      timeout_err           <= terr_d_c;
    end
  end

endmodule

// File: tb/tb_updown_cntr_sequencer.sv
// Directed bench for updown_cntr_sequencer: phase counts, timeout, abort, reset.
module tb_updown_cntr_sequencer;

  logic       clk;
  logic       resetb;
  logic       start;
  logic       abort;
  logic [7:0] cfg_preset_value;
  logic [7:0] cfg_up_cycles;
  logic [7:0] cfg_hold_cycles;
  logic [7:0] cfg_dn_timeout;
  logic       ctr_expired;
  logic       new_cntr_preset;
  logic [7:0] new_cntr_preset_value;
  logic       enable_cnt_up;
  logic       enable_cnt_dn;
  logic       pause_counting;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int errors = 0;
  int checks = 0;

  updown_cntr_sequencer #(.WIDTH(8), .DUR_W(8)) dut (
    .clk                   (clk),
    .resetb                (resetb),
    .start                 (start),
    .abort                 (abort),
    .cfg_preset_value      (cfg_preset_value),
    .cfg_up_cycles         (cfg_up_cycles),
    .cfg_hold_cycles       (cfg_hold_cycles),
    .cfg_dn_timeout        (cfg_dn_timeout),
    .ctr_expired           (ctr_expired),
    .new_cntr_preset       (new_cntr_preset),
    .new_cntr_preset_value (new_cntr_preset_value),
    .enable_cnt_up         (enable_cnt_up),
    .enable_cnt_dn         (enable_cnt_dn),
    .pause_counting        (pause_counting),
    .busy                  (busy),
    .done                  (done),
    .timeout_err           (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [14:0] all_outs();
    return {new_cntr_preset, enable_cnt_up, enable_cnt_dn, pause_counting,
            busy, done, timeout_err, new_cntr_preset_value};
  endfunction

  // Drive a start with a profile; returns at the negedge of the cycle after acceptance.
  task automatic do_start(input logic [7:0] p, input logic [7:0] u,
                          input logic [7:0] h, input logic [7:0] t);
    cfg_preset_value = p;
    cfg_up_cycles    = u;
    cfg_hold_cycles  = h;
    cfg_dn_timeout   = t;
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Walk a running sequence cycle by cycle, tallying each phase until done.
  task automatic run_seq(input int exp_at, input bit disturb, input int max_cyc,
                         output int n_pre, output int n_up, output int n_hold,
                         output int n_dn, output int n_done, output int n_viol,
                         output int n_order, output logic terr_at_done,
                         output logic busy_after, output logic [7:0] val_at_done);
    int  phase;
    int  last_phase;
    int  ctl;
    bit  fin;
    n_pre = 0; n_up = 0; n_hold = 0; n_dn = 0; n_done = 0; n_viol = 0; n_order = 0;
    terr_at_done = 1'b0; busy_after = 1'b1; val_at_done = 8'h00;
    last_phase = 0;
    fin = 1'b0;
    for (int c = 0; c < max_cyc && !fin; c++) begin
      ctl = int'(new_cntr_preset) + int'(enable_cnt_up) + int'(enable_cnt_dn) + int'(pause_counting);
      if (ctl > 1) n_viol++;
      if (!busy) n_order++;
      phase = 0;
      if (new_cntr_preset) phase = 1;
      else if (enable_cnt_up) phase = 2;
      else if (pause_counting) phase = 3;
      else if (enable_cnt_dn) phase = 4;
      else if (done) phase = 5;
      if (phase == 0 || phase < last_phase) n_order++;
      last_phase = phase;
      case (phase)
        1: n_pre++;
        2: n_up++;
        3: n_hold++;
        4: n_dn++;
        5: n_done++;
        default: ;
      endcase
      if (done) begin
        terr_at_done = timeout_err;
        val_at_done  = new_cntr_preset_value;
        ctr_expired  = 1'b0;
        start        = 1'b0;
        @(negedge clk);
        busy_after = busy;
        fin = 1'b1;
      end else begin
        ctr_expired = (exp_at > 0) && (n_dn >= exp_at);
        if (disturb && pause_counting) begin
          start            = 1'b1;
          cfg_preset_value = 8'd99;
          cfg_up_cycles    = 8'd7;
          cfg_hold_cycles  = 8'd1;
          cfg_dn_timeout   = 8'd2;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    ctr_expired = 1'b0;
  endtask

  int         n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order;
  logic       terr_d, busy_a;
  logic [7:0] val_d;

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", all_outs());
    end
    resetb = 1'b1;
    ctr_expired = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || enable_cnt_dn !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignores_expired: busy=%b dn=%b done=%b expected 0 0 0", busy, enable_cnt_dn, done);
    end
    ctr_expired = 1'b0;
    // Reset asserted mid-UP must clear everything asynchronously.
    do_start(8'd5, 8'd10, 8'd0, 8'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (enable_cnt_up !== 1'b1) begin
      errors++;
      $display("FAIL mid_up_setup: enable_cnt_up=%b expected 1", enable_cnt_up);
    end
    #2 resetb = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++;
      $display("FAIL async_reset_outs: got %h expected 0", all_outs());
    end
    @(negedge clk);
    resetb = 1'b1;
    ctr_expired = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (all_outs() !== 15'h0) begin
      errors++;
      $display("FAIL post_reset_idle: got %h expected 0", all_outs());
    end
    ctr_expired = 1'b0;
  endtask

  task automatic test_basic();
    do_start(8'd10, 8'd5, 8'd3, 8'd0);
    checks++;
    if (busy !== 1'b1 || new_cntr_preset !== 1'b1 || new_cntr_preset_value !== 8'd10) begin
      errors++;
      $display("FAIL basic_load: busy=%b pre=%b val=%0d expected 1 1 10", busy, new_cntr_preset, new_cntr_preset_value);
    end
    run_seq(20, 1'b0, 200, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_pre !== 1 || n_up !== 5 || n_hold !== 3 || n_dn !== 20 || n_done !== 1) begin
      errors++;
      $display("FAIL basic_counts: pre=%0d up=%0d hold=%0d dn=%0d done=%0d expected 1 5 3 20 1",
               n_pre, n_up, n_hold, n_dn, n_done);
    end
    checks++;
    if (terr_d !== 1'b0 || busy_a !== 1'b0 || n_viol !== 0 || n_order !== 0 || val_d !== 8'd10) begin
      errors++;
      $display("FAIL basic_status: terr=%b busy_after=%b viol=%0d order=%0d val=%0d expected 0 0 0 0 10",
               terr_d, busy_a, n_viol, n_order, val_d);
    end
  endtask

  task automatic test_timeout();
    do_start(8'd7, 8'd0, 8'd0, 8'd4);
    run_seq(0, 1'b0, 50, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_pre !== 1 || n_up !== 0 || n_hold !== 0 || n_dn !== 4 || n_done !== 1) begin
      errors++;
      $display("FAIL timeout_counts: pre=%0d up=%0d hold=%0d dn=%0d done=%0d expected 1 0 0 4 1",
               n_pre, n_up, n_hold, n_dn, n_done);
    end
    checks++;
    if (terr_d !== 1'b1 || val_d !== 8'd7 || n_order !== 0) begin
      errors++;
      $display("FAIL timeout_err: terr=%b val=%0d order=%0d expected 1 7 0", terr_d, val_d, n_order);
    end
    checks++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_err_hold: terr=%b busy=%b expected 1 0", timeout_err, busy);
    end
  endtask

  task automatic test_expiry_wins();
    do_start(8'd20, 8'd2, 8'd1, 8'd4);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_terr: terr=%b expected 0", timeout_err);
    end
    run_seq(4, 1'b0, 50, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_up !== 2 || n_hold !== 1 || n_dn !== 4 || n_done !== 1 || terr_d !== 1'b0) begin
      errors++;
      $display("FAIL expiry_wins: up=%0d hold=%0d dn=%0d done=%0d terr=%b expected 2 1 4 1 0",
               n_up, n_hold, n_dn, n_done, terr_d);
    end
  endtask

  task automatic test_abort();
    int ups;
    int dones;
    do_start(8'd4, 8'd10, 8'd2, 8'd0);
    ups = 0;
    for (int c = 0; c < 20 && ups < 3; c++) begin
      @(negedge clk);
      if (enable_cnt_up) ups++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (enable_cnt_up !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ups !== 3) begin
      errors++;
      $display("FAIL abort_up: up=%b busy=%b done=%b ups=%0d expected 0 0 0 3", enable_cnt_up, busy, done, ups);
    end
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done || busy || enable_cnt_up || enable_cnt_dn || pause_counting) dones++;
    end
    checks++;
    if (dones !== 0 || new_cntr_preset_value !== 8'd4) begin
      errors++;
      $display("FAIL abort_quiet: active_cycles=%0d val=%0d expected 0 4", dones, new_cntr_preset_value);
    end
    do_start(8'd3, 8'd1, 8'd1, 8'd2);
    run_seq(0, 1'b0, 50, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_pre !== 1 || n_up !== 1 || n_hold !== 1 || n_dn !== 2 || n_done !== 1 || terr_d !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: pre=%0d up=%0d hold=%0d dn=%0d done=%0d terr=%b expected 1 1 1 2 1 1",
               n_pre, n_up, n_hold, n_dn, n_done, terr_d);
    end
  endtask

  task automatic test_ignore_inputs();
    do_start(8'd10, 8'd3, 8'd4, 8'd0);
    run_seq(5, 1'b1, 100, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_up !== 3 || n_hold !== 4 || n_dn !== 5 || n_done !== 1 || val_d !== 8'd10) begin
      errors++;
      $display("FAIL captured_profile: up=%0d hold=%0d dn=%0d done=%0d val=%0d expected 3 4 5 1 10",
               n_up, n_hold, n_dn, n_done, val_d);
    end
    checks++;
    if (n_viol !== 0 || n_order !== 0 || busy_a !== 1'b0 || terr_d !== 1'b0) begin
      errors++;
      $display("FAIL onehot_and_noqueue: viol=%0d order=%0d busy_after=%b terr=%b expected 0 0 0 0",
               n_viol, n_order, busy_a, terr_d);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || new_cntr_preset !== 1'b0) begin
      errors++;
      $display("FAIL no_queued_start: busy=%b pre=%b expected 0 0", busy, new_cntr_preset);
    end
  endtask

  task automatic test_back_to_back();
    do_start(8'd1, 8'd1, 8'd0, 8'd1);
    run_seq(0, 1'b0, 30, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_up !== 1 || n_hold !== 0 || n_dn !== 1 || terr_d !== 1'b1 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: up=%0d hold=%0d dn=%0d terr=%b busy_after=%b expected 1 0 1 1 0",
               n_up, n_hold, n_dn, terr_d, busy_a);
    end
    // Start in the first idle cycle, together with abort: start must win.
    abort = 1'b1;
    do_start(8'd2, 8'd0, 8'd1, 8'd0);
    checks++;
    if (new_cntr_preset !== 1'b1 || new_cntr_preset_value !== 8'd2 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_load: pre=%b val=%0d busy=%b terr=%b expected 1 2 1 0",
               new_cntr_preset, new_cntr_preset_value, busy, timeout_err);
    end
    run_seq(1, 1'b0, 30, n_pre, n_up, n_hold, n_dn, n_done, n_viol, n_order, terr_d, busy_a, val_d);
    checks++;
    if (n_up !== 0 || n_hold !== 1 || n_dn !== 1 || n_done !== 1 || terr_d !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: up=%0d hold=%0d dn=%0d done=%0d terr=%b expected 0 1 1 1 0",
               n_up, n_hold, n_dn, n_done, terr_d);
    end
  endtask

  initial begin
    resetb           = 1'b0;
    start            = 1'b0;
    abort            = 1'b0;
    cfg_preset_value = 8'h00;
    cfg_up_cycles    = 8'h00;
    cfg_hold_cycles  = 8'h00;
    cfg_dn_timeout   = 8'h00;
    ctr_expired      = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
    test_expiry_wins();
    test_abort();
    test_ignore_inputs();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_cntr_sequencer.md
# updown_cntr_sequencer

Control-side sequencer for the preset-able up/down counter. On a `start` command it captures a count profile, loads the counter preset, runs the counter up for a programmed number of cycles, holds it paused, then runs it down until the counter reports `ctr_expired` or a watchdog times out. It sits between the host control registers and the counter's control pins, and is the only driver of those pins.

## Interface
- `WIDTH`, 8, width of the counter preset value
- `DUR_W`, 8, width of the phase-duration and timeout fields
- `clk`  in  1  system clock; all state updates on the rising edge
- `resetb`  in  1  asynchronous, active-low reset
- `start`  in  1  sampled high in IDLE: capture the `cfg_*` fields and begin a sequence
- `abort`  in  1  sampled high in any non-IDLE state: stop the sequence
- `cfg_preset_value`  in  WIDTH  value to load into the counter
- `cfg_up_cycles`  in  DUR_W  number of count-up cycles (0 skips the UP phase)
- `cfg_hold_cycles`  in  DUR_W  number of pause cycles (0 skips the HOLD phase)
- `cfg_dn_timeout`  in  DUR_W  maximum number of DOWN cycles (0 means no timeout)
- `ctr_expired`  in  1  expiry flag from the counter
- `new_cntr_preset`  out  1  preset-load strobe to the counter
- `new_cntr_preset_value`  out  WIDTH  preset value to the counter
- `enable_cnt_up`  out  1  count-up enable to the counter
- `enable_cnt_dn`  out  1  count-down enable to the counter
- `pause_counting`  out  1  pause to the counter
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse on sequence completion
- `timeout_err`  out  1  set when the sequence ended by timeout; valid from `done` until the next accepted `start`

## Operation
- **State machine.** The FSM has six states: IDLE, LOAD, UP, HOLD, DOWN, DONE. All outputs are registered and decoded from the current state.
- **Reset.** While `resetb` is low:
  - the FSM is in IDLE;
  - every output is 0, including `new_cntr_preset_value`;
  - the shadow configuration registers and the duration counter are 0.
- **IDLE.**
  - If `start` = 1, latch all `cfg_*` fields into shadow registers, clear `timeout_err`, and go to LOAD.
  - The `cfg_*` inputs are ignored at every other time.
- **LOAD.**
  - Drive `new_cntr_preset` = 1 for exactly one cycle, with `new_cntr_preset_value` = the shadowed preset.
  - Next state: UP if up ≠ 0; otherwise HOLD if hold ≠ 0; otherwise DOWN.
- **UP.**
  - Drive `enable_cnt_up` = 1 for exactly `cfg_up_cycles` cycles, tracked by a duration counter.
  - Then go to HOLD, or to DOWN if hold = 0.
- **HOLD.** Drive `pause_counting` = 1 and both enables = 0 for exactly `cfg_hold_cycles` cycles, then go to DOWN.
- **DOWN.**
  - Drive `enable_cnt_dn` = 1.
  - If `ctr_expired` is sampled 1, go to DONE with `timeout_err` = 0.
  - Otherwise, if timeout ≠ 0 and the DOWN cycle count reaches timeout, go to DONE with `timeout_err` = 1.
  - If both conditions occur in the same cycle, expiry wins (`timeout_err` = 0).
- **DONE.** Pulse `done` = 1 for one cycle, then go to IDLE.
- **Abort.**
  - `abort` sampled 1 in LOAD, UP, HOLD or DOWN sends the FSM to IDLE.
  - All counter controls are 0 from the next cycle; no `done` pulse is issued and `timeout_err` is unchanged.
  - `abort` in IDLE or DONE has no effect.
  - If `abort` and `start` are both high in IDLE, `start` is accepted.
- **Ignored inputs.**
  - `start` while `busy` is ignored; no queuing.
  - `ctr_expired` is ignored outside DOWN.
- **Output invariants.**
  - At most one of `new_cntr_preset`, `enable_cnt_up`, `enable_cnt_dn`, `pause_counting` is high in any cycle.
  - `new_cntr_preset_value` holds the shadowed preset from LOAD until the next accepted `start`.
- **Duration counter.**
  - DUR_W bits wide, cleared on every state entry; it never wraps.
  - The maximum programmable duration is 2^DUR_W − 1.

## Timing
- `start` sampled at edge k:
  - `busy` and `new_cntr_preset` are high in cycle k+1;
  - `enable_cnt_up` is high in cycles k+2 … k+1+U.
- HOLD occupies the H cycles that immediately follow the last UP cycle; DOWN begins the cycle after that.
- `ctr_expired` sampled at edge m in DOWN:
  - `enable_cnt_dn` goes low and `done` = 1 in cycle m+1;
  - `busy` is low in cycle m+2.
- The earliest next accepted `start` is the cycle in which `busy` is low.
- Timeout T: DOWN lasts exactly T cycles, then DONE.
- Asynchronous reset mid-sequence clears all outputs immediately. Counter controls must not glitch high on reset release.

## Test plan
- Reset, then hold `resetb` low mid-UP → all outputs 0 immediately; after release the FSM stays in IDLE and ignores `ctr_expired`.
- `start` with preset 10, up 5, hold 3, timeout 0; `ctr_expired` asserted 20 cycles into DOWN → 1 preset strobe (value 10), then 5 up, 3 pause and 20 dn cycles, `done` once, `timeout_err` = 0.
- preset 7, up 0, hold 0, timeout 4, `ctr_expired` never asserted → LOAD goes directly to DOWN; exactly 4 dn cycles; `done` with `timeout_err` = 1.
- `ctr_expired` high on the same cycle the timeout count is reached (timeout 4) → `timeout_err` = 0.
- `abort` on the 3rd UP cycle (up 10) → `enable_cnt_up` low next cycle, `busy` low, no `done`; a following `start` is accepted normally.
- `start` pulsed during HOLD, and `cfg_*` changed mid-sequence → no effect; the running profile uses the captured values; the one-hot invariant on counter controls holds throughout.
